// File: rtl/jelly_capacity_arbiter.sv
// jelly_capacity_arbiter
// N per-channel capacity accumulators drained by a round-robin arbiter into
// one registered valid/ready issue port tagged with the channel id. Each
// issue is clipped to MAX_ISSUE_SIZE when that parameter is nonzero.
// Build option: define JELLY_CAPACITY_ARBITER_SATURATE_EN to clamp the
// accumulators at all-ones on overflow instead of wrapping.

module jelly_capacity_arbiter #(
  parameter int                        N                   = 4,
  parameter int                        ID_WIDTH            = 2,
  parameter int                        CAPACITY_WIDTH      = 32,
  parameter int                        REQUEST_WIDTH       = CAPACITY_WIDTH,
  parameter int                        ISSUE_WIDTH         = CAPACITY_WIDTH,
  parameter logic [REQUEST_WIDTH-1:0]  REQUEST_SIZE_OFFSET = '0,
  parameter logic [ISSUE_WIDTH-1:0]    ISSUE_SIZE_OFFSET   = '0,
  parameter logic [CAPACITY_WIDTH-1:0] MAX_ISSUE_SIZE      = '0
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cke,
  input  logic [N*REQUEST_WIDTH-1:0]  s_request_size,
  input  logic [N-1:0]                s_request_valid,
  output logic [N*CAPACITY_WIDTH-1:0] queued_request,
  output logic [ID_WIDTH-1:0]         m_issue_id,
  output logic [ISSUE_WIDTH-1:0]      m_issue_size,
  output logic                        m_issue_valid,
  input  logic                        m_issue_ready,
  output logic                        busy
);

`ifdef JELLY_CAPACITY_ARBITER_SATURATE_EN
  localparam int SUM_WIDTH =
    ((CAPACITY_WIDTH > REQUEST_WIDTH + 1) ? CAPACITY_WIDTH : REQUEST_WIDTH + 1) + 1;
  localparam logic [CAPACITY_WIDTH-1:0] ACC_MAX = '1;

  logic [REQUEST_WIDTH:0]  add;
  logic [SUM_WIDTH-1:0]    sum;
`endif

  logic [CAPACITY_WIDTH-1:0] acc      [N];
  logic [CAPACITY_WIDTH-1:0] acc_next [N];
  logic [CAPACITY_WIDTH-1:0] deduct;
  logic [ID_WIDTH-1:0]       ptr;

  logic                      free;
  logic                      grant;
  logic                      found;
  logic                      found_hi;
  logic                      found_lo;
  logic [ID_WIDTH-1:0]       winner;
  logic [ID_WIDTH-1:0]       win_hi;
  logic [ID_WIDTH-1:0]       win_lo;
  logic [CAPACITY_WIDTH-1:0] winner_acc;
  logic [CAPACITY_WIDTH-1:0] acc_hi;
  logic [CAPACITY_WIDTH-1:0] acc_lo;
  logic [CAPACITY_WIDTH-1:0] amt;

  // The output slot may be reloaded when empty or being accepted this cycle.
  assign free  = !m_issue_valid || m_issue_ready;
  assign grant = cke && free && found;
  assign amt   = (MAX_ISSUE_SIZE != '0 && winner_acc > MAX_ISSUE_SIZE) ? MAX_ISSUE_SIZE
                                                                       : winner_acc;

  // Round-robin search: first nonzero channel above the pointer, else the first at or below it.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default first, so no path infers a latch.
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    acc_hi   = '0;
    acc_lo   = '0;
    for (int i = 0; i < N; i++) begin
      if (acc[i] != '0) begin
        if (ID_WIDTH'(i) > ptr) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            win_hi   = ID_WIDTH'(i);
            acc_hi   = acc[i];
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = ID_WIDTH'(i);
          acc_lo   = acc[i];
        end
      end
    end
    found      = found_hi | found_lo;
    winner     = found_hi ? win_hi : win_lo;
    winner_acc = found_hi ? acc_hi : acc_lo;
  end

  // Next accumulator value: deduct the grant first, then add any new request so it is never lost.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      deduct = (grant && winner == ID_WIDTH'(i)) ? amt : '0;
`ifdef JELLY_CAPACITY_ARBITER_SATURATE_EN
      add = s_request_valid[i]
          ? ({1'b0, s_request_size[i*REQUEST_WIDTH +: REQUEST_WIDTH]} + {1'b0, REQUEST_SIZE_OFFSET})
          : '0;
      sum = SUM_WIDTH'(acc[i] - deduct) + SUM_WIDTH'(add);
      acc_next[i] = (sum > SUM_WIDTH'(ACC_MAX)) ? ACC_MAX : sum[CAPACITY_WIDTH-1:0];
`else
      acc_next[i] = acc[i] - deduct;
      if (s_request_valid[i]) begin
        acc_next[i] = acc_next[i]
                    + CAPACITY_WIDTH'(s_request_size[i*REQUEST_WIDTH +: REQUEST_WIDTH])
                    + CAPACITY_WIDTH'(REQUEST_SIZE_OFFSET);
      end
`endif
    end
  end

  // Accumulator registers, frozen while the clock enable is low.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: acc is a handful of flops rather than a RAM, so every entry is cleared by reset.
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else if (cke) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < N; i++) acc[i] <= acc_next[i];
    end
  end

  // Issue register and round-robin pointer; held stable while stalled by the consumer.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_issue_valid <= 1'b0;
      m_issue_id    <= '0;
      m_issue_size  <= '0;
      ptr           <= ID_WIDTH'(N - 1);
    end else if (cke && free) begin
      m_issue_valid <= found;
      if (found) begin
        m_issue_id   <= winner;
        m_issue_size <= ISSUE_WIDTH'(amt) - ISSUE_SIZE_OFFSET;
        ptr          <= winner;
      end
    end
  end

  // Expose the accumulators and summarise activity.
  always_comb begin
    queued_request = '0;
    busy           = m_issue_valid;
    for (int i = 0; i < N; i++) begin
      queued_request[i*CAPACITY_WIDTH +: CAPACITY_WIDTH] = acc[i];
      if (acc[i] != '0) busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_jelly_capacity_arbiter.sv
// Testbench for jelly_capacity_arbiter: two instances (32-bit unclipped, and
// 8-bit with clip limit 4) share one stimulus stream. A behavioural model
// queues each expected issue; a monitor pops and compares on every handshake
// and compares the accumulators, busy and the issue port every cycle.
`timescale 1ns/1ps

module tb_jelly_capacity_arbiter;

  localparam int N    = 4;
  localparam int CWA  = 32;
  localparam int CWB  = 8;

  typedef struct {
    int     id;
    longint size;
  } issue_t;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              cke;
  logic              ready;
  logic [N-1:0]      req_valid;
  logic [N*CWA-1:0]  size_a;
  logic [N*CWB-1:0]  size_b;

  logic [N*CWA-1:0]  qr_a;
  logic [N*CWB-1:0]  qr_b;
  logic [1:0]        id_a, id_b;
  logic [CWA-1:0]    isz_a;
  logic [CWB-1:0]    isz_b;
  logic              iv_a, iv_b;
  logic              busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0 = instance a, 1 = instance b.
  longint acc_m [2][N];
  int     ptr_m [2];
  bit     vld_m [2];
  int     id_m  [2];
  longint sz_m  [2];
  longint cap_mask [2];
  longint clip_lim [2];
  issue_t q_a [$];
  issue_t q_b [$];

  always #5 aclk = ~aclk;

  jelly_capacity_arbiter #(
    .N(N), .ID_WIDTH(2), .CAPACITY_WIDTH(CWA)
  ) u_dut_a (
    .aclk(aclk), .aresetn(aresetn), .cke(cke),
    .s_request_size(size_a), .s_request_valid(req_valid),
    .queued_request(qr_a), .m_issue_id(id_a), .m_issue_size(isz_a),
    .m_issue_valid(iv_a), .m_issue_ready(ready), .busy(busy_a)
  );

  jelly_capacity_arbiter #(
    .N(N), .ID_WIDTH(2), .CAPACITY_WIDTH(CWB), .MAX_ISSUE_SIZE(8'd4)
  ) u_dut_b (
    .aclk(aclk), .aresetn(aresetn), .cke(cke),
    .s_request_size(size_b), .s_request_valid(req_valid),
    .queued_request(qr_b), .m_issue_id(id_b), .m_issue_size(isz_b),
    .m_issue_valid(iv_b), .m_issue_ready(ready), .busy(busy_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint req_size(input int k, input int i);
    if (k == 0) return longint'(size_a[i*CWA +: CWA]);
    return longint'(size_b[i*CWB +: CWB]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < N; i++) acc_m[k][i] = 0;
      ptr_m[k] = N - 1;
      vld_m[k] = 1'b0;
      id_m[k]  = 0;
      sz_m[k]  = 0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  // One enabled clock edge of the scheduler, from its rules.
  task automatic model_edge(input int k);
    int     win;
    int     c;
    longint amt;
    issue_t e;
    if (!vld_m[k] || ready) begin
      win = -1;
      for (int j = 1; j <= N; j++) begin
        c = (ptr_m[k] + j) % N;
        if (win < 0 && acc_m[k][c] != 0) win = c;
      end
      if (win >= 0) begin
        amt = acc_m[k][win];
        if (clip_lim[k] != 0 && amt > clip_lim[k]) amt = clip_lim[k];
        acc_m[k][win] -= amt;
        vld_m[k] = 1'b1;
        id_m[k]  = win;
        sz_m[k]  = amt;
        ptr_m[k] = win;
        e.id   = win;
        e.size = amt;
        if (k == 0) q_a.push_back(e);
        else        q_b.push_back(e);
      end else begin
        vld_m[k] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        acc_m[k][i] += req_size(k, i);
`ifdef JELLY_CAPACITY_ARBITER_SATURATE_EN
        if (acc_m[k][i] > cap_mask[k]) acc_m[k][i] = cap_mask[k];
`else
        acc_m[k][i] = acc_m[k][i] & cap_mask[k];
`endif
      end
    end
  endtask

  function automatic bit model_busy(input int k);
    bit b = vld_m[k];
    for (int i = 0; i < N; i++) if (acc_m[k][i] != 0) b = 1'b1;
    return b;
  endfunction

  task automatic compare_instance(input int k);
    string  sfx;
    longint qv, dv_id, dv_sz;
    bit     dv_v, dv_b;
    issue_t e;
    sfx   = (k == 0) ? "a" : "b";
    dv_v  = (k == 0) ? iv_a : iv_b;
    dv_b  = (k == 0) ? busy_a : busy_b;
    dv_id = (k == 0) ? longint'(id_a) : longint'(id_b);
    dv_sz = (k == 0) ? longint'(isz_a) : longint'(isz_b);
    check($sformatf("valid_%s", sfx), dv_v, vld_m[k]);
    check($sformatf("busy_%s", sfx), dv_b, model_busy(k));
    for (int i = 0; i < N; i++) begin
      qv = (k == 0) ? longint'(qr_a[i*CWA +: CWA]) : longint'(qr_b[i*CWB +: CWB]);
      check($sformatf("queued_%s%0d", sfx, i), qv, acc_m[k][i]);
    end
    if (vld_m[k]) begin
      check($sformatf("issue_id_%s", sfx), dv_id, id_m[k]);
      check($sformatf("issue_size_%s", sfx), dv_sz, sz_m[k]);
    end
    if (dv_v && ready && cke) begin
      check($sformatf("sb_pending_%s", sfx), ((k == 0) ? q_a.size() : q_b.size()) != 0, 1);
      if ((k == 0 && q_a.size() != 0) || (k == 1 && q_b.size() != 0)) begin
        e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
        check($sformatf("sb_id_%s", sfx), dv_id, e.id);
        check($sformatf("sb_size_%s", sfx), dv_sz, e.size);
      end
    end
  endtask

  // Model process: advances in lockstep with the DUT clock and reset.
  initial begin
    cap_mask[0] = 64'hFFFF_FFFF;
    cap_mask[1] = 64'hFF;
    clip_lim[0] = 0;
    clip_lim[1] = 4;
    model_reset();
    forever begin
      @(posedge aclk or negedge aresetn);
      if (!aresetn)  model_reset();
      else if (cke) begin
        model_edge(0);
        model_edge(1);
      end
    end
  end

  // Monitor: compares mid-cycle, away from the active edge.
  initial begin
    @(posedge aclk);
    forever begin
      @(negedge aclk);
      compare_instance(0);
      compare_instance(1);
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic req(input int ch, input int unsigned sa, input int unsigned sb);
    req_valid[ch]        = 1'b1;
    size_a[ch*CWA +: CWA] = CWA'(sa);
    size_b[ch*CWB +: CWB] = CWB'(sb);
  endtask

  task automatic clear_req();
    req_valid = '0;
    size_a    = '0;
    size_b    = '0;
  endtask

  task automatic reset_pulse();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    cke     = 1'b1;
    ready   = 1'b1;
    clear_req();
    repeat (3) step();
    aresetn = 1'b1;
    step();

    // Single request on channel 0.
    req(0, 5, 5); step(); clear_req();
    repeat (5) step();

    // All channels at once: round-robin order 0,1,2,3.
    for (int i = 0; i < N; i++) req(i, 8, 8);
    step(); clear_req();
    repeat (10) step();

    // Clipping with interleave (instance b clips at 4).
    reset_pulse();
    req(1, 10, 10); req(2, 3, 3); step(); clear_req();
    repeat (8) step();

    // Stalled issue holds while channel 0 keeps accumulating.
    ready = 1'b0;
    req(0, 6, 6); step();
    req(0, 2, 2);
    repeat (5) step();
    clear_req();
    check("t4_hold_size_a", isz_a, 6);
    check("t4_acc0_a", qr_a[CWA-1:0], 10);
    ready = 1'b1;
    step();
    check("t4_next_size_a", isz_a, 10);
    repeat (8) step();

    // Accumulator overflow behind a stalled issue.
    reset_pulse();
    ready = 1'b0;
    req(1, 1, 1); step(); clear_req();
    step();
    req(0, 250, 250); step();
    req(0, 10, 10); step(); clear_req();
`ifdef JELLY_CAPACITY_ARBITER_SATURATE_EN
    check("t5_acc0_b", qr_b[CWB-1:0], 255);
`else
    check("t5_acc0_b", qr_b[CWB-1:0], 4);
`endif
    check("t5_acc0_a", qr_a[CWA-1:0], 260);
    ready = 1'b1;
    repeat (70) step();

    // Reset while an issue is pending and channel 2 holds 7.
    ready = 1'b0;
    req(1, 1, 1); step(); clear_req();
    step();
    req(2, 7, 7); step(); clear_req();
    #2 aresetn = 1'b0;
    #1;
    check("t6_valid_a", iv_a, 0);
    check("t6_valid_b", iv_b, 0);
    check("t6_queued_a", qr_a != '0, 0);
    check("t6_queued_b", qr_b != '0, 0);
    check("t6_busy_a", busy_a, 0);
    step();
    aresetn = 1'b1;
    ready   = 1'b1;
    req(3, 2, 2); req(0, 2, 2); step(); clear_req();
    step();
    check("t6_first_id_a", id_a, 0);
    repeat (5) step();

    // Randomised traffic with stalls, clock-enable gaps and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      cke   = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) == 0);
        size_a[i*CWA +: CWA] = ($urandom_range(0, 15) == 0) ? CWA'($urandom)
                                                            : CWA'($urandom_range(0, 20));
        size_b[i*CWB +: CWB] = ($urandom_range(0, 15) == 0) ? CWB'($urandom_range(150, 255))
                                                            : CWB'($urandom_range(0, 9));
      end
      aresetn = ($urandom_range(0, 399) != 0);
      step();
    end

    // Drain everything.
    aresetn = 1'b1;
    cke     = 1'b1;
    ready   = 1'b1;
    clear_req();
    repeat (300) step();
    check("drain_queue_a", q_a.size(), 0);
    check("drain_queue_b", q_b.size(), 0);
    check("drain_busy_a", busy_a, 0);
    check("drain_busy_b", busy_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
